// File: rtl/keypad_calc_pkg.sv
// Shared types and constants for the keypad BCD calculator.
// Key codes, FSM/op encodings and small operand helpers.
package keypad_calc_pkg;

  localparam logic [3:0]  KEY_ADD      = 4'hA;
  localparam logic [3:0]  KEY_SUB      = 4'hB;
  localparam logic [3:0]  KEY_CLR      = 4'hC;
  localparam logic [3:0]  KEY_BS       = 4'hD;
  localparam logic [3:0]  KEY_EQ       = 4'hF;
  localparam logic [15:0] ERR_CODE_DEF = 16'hEEEE;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTRY_B = 3'd2,
    ST_CALC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_t;

  // Number of significant digits, so backspace after a result behaves like typed entry
  function automatic logic [2:0] sig_digits(input logic [15:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] != 4'h0) begin
        n = 3'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  function automatic op_t key_to_op(input logic [3:0] k);
    return (k == KEY_SUB) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/keypad_bcd_calc_if.sv
// Scanner handshake plus display/status bundle for the calculator.
interface keypad_bcd_calc_if;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_ack;
  logic [15:0] disp_data;
  logic        busy;
  logic        err;

  modport master (output key_code, key_ready, input key_ack, disp_data, busy, err);
  modport slave  (input key_code, key_ready, output key_ack, disp_data, busy, err);
endinterface

// File: rtl/bcd_digit_addsub.sv
// One BCD digit add/subtract slice; time-multiplexed across the operand digits.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum_s;
  logic [4:0] diff_s;

  // Binary result per digit, then decimal correction on overflow/borrow
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    diff_s = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
    s      = 4'h0;
    cout   = 1'b0;
    if (sub) begin
      if (diff_s[4]) begin
        s    = diff_s[3:0] - 4'd6;
        cout = 1'b1;
      end else begin
        s    = diff_s[3:0];
        cout = 1'b0;
      end
    end else begin
      if (sum_s > 5'd9) begin
        s    = sum_s[3:0] + 4'd6;
        cout = 1'b1;
      end else begin
        s    = sum_s[3:0];
        cout = 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_bcd_calc.sv
// 4-digit BCD add/subtract calculator fed by the keypad scanner handshake.
// Arithmetic runs LSD first, one digit per clock, through a single digit slice.
module keypad_bcd_calc
  import keypad_calc_pkg::*;
#(
  parameter logic [15:0] ERR_CODE = ERR_CODE_DEF,
  parameter int          NDIG     = 4
) (
  input logic               clk,
  input logic               rst_n,
  keypad_bcd_calc_if.slave  bus
);

  state_t      state_r, state_nx;
  state_t      ret_r, ret_nx;
  op_t         op_r, op_nx;
  op_t         pend_op_r, pend_op_nx;
  logic [15:0] a_r, a_nx;
  logic [15:0] b_r, b_nx;
  logic [15:0] res_r, res_nx;
  logic [15:0] disp_r, disp_nx;
  logic [2:0]  cnt_r, cnt_nx;
  logic [2:0]  idx_r, idx_nx;
  logic        carry_r, carry_nx;
  logic        armed_r, armed_nx;
  logic        ack_r, ack_nx;
  logic        busy_r, busy_nx;
  logic        err_r, err_nx;

  logic        accept_s;
  logic        is_digit_s;
  logic        is_op_s;
  logic        full_s;
  logic [3:0]  dig_a_s;
  logic [3:0]  dig_b_s;
  logic [3:0]  dig_s_s;
  logic        dig_cout_s;

  assign accept_s   = bus.key_ready && armed_r && (state_r != ST_CALC);
  assign is_digit_s = (bus.key_code <= 4'd9);
  assign is_op_s    = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB);
  assign full_s     = (cnt_r == 3'(NDIG));
  assign dig_a_s    = a_r[{idx_r[1:0], 2'b00} +: 4];
  assign dig_b_s    = b_r[{idx_r[1:0], 2'b00} +: 4];

  bcd_digit_addsub u_digit (
    .a    (dig_a_s),
    .b    (dig_b_s),
    .cin  (carry_r),
    .sub  (op_r == OP_SUB),
    .s    (dig_s_s),
    .cout (dig_cout_s)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_nx   = state_r;
    ret_nx     = ret_r;
    op_nx      = op_r;
    pend_op_nx = pend_op_r;
    a_nx       = a_r;
    b_nx       = b_r;
    res_nx     = res_r;
    cnt_nx     = cnt_r;
    idx_nx     = idx_r;
    carry_nx   = carry_r;
    busy_nx    = busy_r;
    err_nx     = err_r;
    ack_nx     = 1'b0;
    disp_nx    = disp_r;

    if (!bus.key_ready) begin
      armed_nx = 1'b1;
    end else if (accept_s) begin
      armed_nx = 1'b0;
    end else begin
      armed_nx = armed_r;
    end

    if (state_r == ST_CALC) begin
      if (!idx_r[2]) begin
        res_nx[{idx_r[1:0], 2'b00} +: 4] = dig_s_s;
        carry_nx = dig_cout_s;
        idx_nx   = idx_r + 3'd1;
      end else begin
        busy_nx = 1'b0;
        if (carry_r) begin
          state_nx = ST_ERROR;
          err_nx   = 1'b1;
        end else begin
          state_nx = ret_r;
          a_nx     = res_r;
          b_nx     = 16'h0000;
          cnt_nx   = sig_digits(res_r);
          op_nx    = (ret_r == ST_OP_WAIT) ? pend_op_r : op_r;
        end
      end
    end else if (accept_s) begin
      ack_nx = 1'b1;
      if (bus.key_code == KEY_CLR) begin
        state_nx   = ST_ENTRY_A;
        ret_nx     = ST_ENTRY_A;
        op_nx      = OP_NONE;
        pend_op_nx = OP_NONE;
        a_nx       = 16'h0000;
        b_nx       = 16'h0000;
        res_nx     = 16'h0000;
        cnt_nx     = 3'd0;
        idx_nx     = 3'd0;
        carry_nx   = 1'b0;
        busy_nx    = 1'b0;
        err_nx     = 1'b0;
      end else begin
        case (state_r)
          ST_ENTRY_A: begin
            if (is_digit_s) begin
              if (!full_s && !((a_r == 16'h0000) && (bus.key_code == 4'h0))) begin
                a_nx   = {a_r[11:0], bus.key_code};
                cnt_nx = cnt_r + 3'd1;
              end else begin
                a_nx = a_r;
              end
            end else if (is_op_s) begin
              op_nx    = key_to_op(bus.key_code);
              state_nx = ST_OP_WAIT;
            end else if (bus.key_code == KEY_BS) begin
              a_nx   = {4'h0, a_r[15:4]};
              cnt_nx = (cnt_r == 3'd0) ? 3'd0 : cnt_r - 3'd1;
            end else begin
              state_nx = state_r;
            end
          end
          ST_OP_WAIT: begin
            if (is_digit_s) begin
              b_nx     = {12'h000, bus.key_code};
              cnt_nx   = 3'd1;
              state_nx = ST_ENTRY_B;
            end else if (is_op_s) begin
              op_nx = key_to_op(bus.key_code);
            end else begin
              state_nx = state_r;
            end
          end
          ST_ENTRY_B: begin
            if (is_digit_s) begin
              if (!full_s && !((b_r == 16'h0000) && (bus.key_code == 4'h0))) begin
                b_nx   = {b_r[11:0], bus.key_code};
                cnt_nx = cnt_r + 3'd1;
              end else begin
                b_nx = b_r;
              end
            end else if (bus.key_code == KEY_BS) begin
              b_nx   = {4'h0, b_r[15:4]};
              cnt_nx = (cnt_r == 3'd0) ? 3'd0 : cnt_r - 3'd1;
            end else if (is_op_s || (bus.key_code == KEY_EQ)) begin
              // A chained operator is held aside until the pending result lands in A
              state_nx   = ST_CALC;
              ret_nx     = is_op_s ? ST_OP_WAIT : ST_RESULT;
              pend_op_nx = is_op_s ? key_to_op(bus.key_code) : pend_op_r;
              busy_nx    = 1'b1;
              idx_nx     = 3'd0;
              carry_nx   = 1'b0;
              res_nx     = 16'h0000;
            end else begin
              state_nx = state_r;
            end
          end
          ST_RESULT: begin
            if (is_digit_s) begin
              a_nx     = {12'h000, bus.key_code};
              cnt_nx   = (bus.key_code == 4'h0) ? 3'd0 : 3'd1;
              state_nx = ST_ENTRY_A;
            end else if (is_op_s) begin
              op_nx    = key_to_op(bus.key_code);
              state_nx = ST_OP_WAIT;
            end else begin
              state_nx = state_r;
            end
          end
          default: begin
            state_nx = state_r;
          end
        endcase
      end
    end else begin
      state_nx = state_r;
    end

    case (state_nx)
      ST_ERROR:   disp_nx = ERR_CODE;
      ST_ENTRY_B: disp_nx = b_nx;
      ST_CALC:    disp_nx = disp_r;
      default:    disp_nx = a_nx;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ENTRY_A;
      ret_r     <= ST_ENTRY_A;
      op_r      <= OP_NONE;
      pend_op_r <= OP_NONE;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      res_r     <= 16'h0000;
      disp_r    <= 16'h0000;
      cnt_r     <= 3'd0;
      idx_r     <= 3'd0;
      carry_r   <= 1'b0;
      armed_r   <= 1'b1;
      ack_r     <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      ret_r     <= ret_nx;
      op_r      <= op_nx;
      pend_op_r <= pend_op_nx;
      a_r       <= a_nx;
      b_r       <= b_nx;
      res_r     <= res_nx;
      disp_r    <= disp_nx;
      cnt_r     <= cnt_nx;
      idx_r     <= idx_nx;
      carry_r   <= carry_nx;
      armed_r   <= armed_nx;
      ack_r     <= ack_nx;
      busy_r    <= busy_nx;
      err_r     <= err_nx;
    end
  end

  assign bus.key_ack   = ack_r;
  assign bus.disp_data = disp_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_keypad_bcd_calc.sv
// Directed self-checking bench for keypad_bcd_calc with hand-computed expectations.
module tb_keypad_bcd_calc;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   ack_cnt;
  int   long_ack;
  logic prev_ack;

  keypad_bcd_calc_if kif ();

  keypad_bcd_calc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ack pulses and flag any that last more than one cycle
  always @(negedge clk) begin
    if (kif.key_ack) begin
      ack_cnt = ack_cnt + 1;
      if (prev_ack) long_ack = long_ack + 1;
    end
    prev_ack = kif.key_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    int n;
    n = 0;
    @(negedge clk);
    kif.key_code  = k;
    kif.key_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.key_ack && n < 50);
    if (!kif.key_ack) check("ack_timeout", 32'(kif.key_ack), 32'd1);
    kif.key_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_seq(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) press(seq[(n-1-i)*4 +: 4]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (kif.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(kif.busy), 32'd0);
  endtask

  initial begin
    int a0;
    int nb;
    int n;
    logic got_ack;
    logic busy_at_ack;

    n_checks = 0;
    n_errors = 0;
    ack_cnt  = 0;
    long_ack = 0;
    prev_ack = 1'b0;
    kif.key_code  = 4'h0;
    kif.key_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_ack",  32'(kif.key_ack),   32'd0);
    check("rst_disp", 32'(kif.disp_data), 32'h0);
    check("rst_busy", 32'(kif.busy),      32'd0);
    check("rst_err",  32'(kif.err),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry with single-cycle acks
    a0 = ack_cnt;
    press_seq(32'h123, 3);
    check("entry_acks", 32'(ack_cnt - a0), 32'd3);
    check("entry_disp", 32'(kif.disp_data), 32'h0123);
    check("entry_err",  32'(kif.err), 32'd0);

    // Fifth digit dropped, then backspace
    press_seq(32'hC99999, 6);
    check("full_disp", 32'(kif.disp_data), 32'h9999);
    press(4'hD);
    check("bs_disp", 32'(kif.disp_data), 32'h0999);

    // 12+34 with busy window measurement
    press_seq(32'hC12A34, 6);
    @(negedge clk);
    kif.key_code  = 4'hF;
    kif.key_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kif.key_ack && n < 50);
    nb = 0;
    while (kif.busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    kif.key_ready = 1'b0;
    check("busy_cycles", 32'(nb), 32'd5);
    check("add_disp", 32'(kif.disp_data), 32'h0046);
    press(4'h7);
    check("result_newdigit", 32'(kif.disp_data), 32'h0007);

    // Chained operations
    press_seq(32'hC2A3A, 5);
    wait_idle();
    check("chain_mid", 32'(kif.disp_data), 32'h0005);
    press_seq(32'h4F, 2);
    wait_idle();
    check("chain_end", 32'(kif.disp_data), 32'h0009);

    // Carry and borrow propagation across digits
    press_seq(32'hC999A1F, 7);
    wait_idle();
    check("add_carry", 32'(kif.disp_data), 32'h1000);
    press_seq(32'hC1000B1F, 8);
    wait_idle();
    check("sub_borrow", 32'(kif.disp_data), 32'h0999);
    press_seq(32'hC50B7F, 6);
    wait_idle();
    check("sub_disp", 32'(kif.disp_data), 32'h0043);

    // Negative result and overflow both go to error
    press_seq(32'hC5B7F, 5);
    wait_idle();
    check("neg_err",  32'(kif.err), 32'd1);
    check("neg_disp", 32'(kif.disp_data), 32'hEEEE);
    press_seq(32'hC9999A1F, 8);
    wait_idle();
    check("ovf_err",  32'(kif.err), 32'd1);
    check("ovf_disp", 32'(kif.disp_data), 32'hEEEE);
    a0 = ack_cnt;
    press(4'h1);
    check("errkey_ack",  32'(ack_cnt - a0), 32'd1);
    check("errkey_disp", 32'(kif.disp_data), 32'hEEEE);
    press(4'hC);
    check("clr_disp", 32'(kif.disp_data), 32'h0);
    check("clr_err",  32'(kif.err), 32'd0);

    // Held key_ready gives exactly one acceptance
    a0 = ack_cnt;
    @(negedge clk);
    kif.key_code  = 4'h1;
    kif.key_ready = 1'b1;
    repeat (20) @(negedge clk);
    kif.key_ready = 1'b0;
    @(negedge clk);
    check("hold_acks", 32'(ack_cnt - a0), 32'd1);
    check("hold_disp", 32'(kif.disp_data), 32'h0001);

    // Key presented during CALC waits for completion
    press_seq(32'hC2A3F, 5);
    kif.key_code  = 4'h7;
    kif.key_ready = 1'b1;
    a0 = ack_cnt;
    got_ack = 1'b0;
    busy_at_ack = 1'b1;
    n = 0;
    while (!got_ack && n < 30) begin
      @(negedge clk);
      n++;
      if (kif.key_ack) begin
        got_ack = 1'b1;
        busy_at_ack = kif.busy;
      end
    end
    kif.key_ready = 1'b0;
    @(negedge clk);
    check("calc_key_ack",  32'(got_ack), 32'd1);
    check("calc_key_busy", 32'(busy_at_ack), 32'd0);
    check("calc_key_once", 32'(ack_cnt - a0), 32'd1);
    check("calc_key_disp", 32'(kif.disp_data), 32'h0007);

    // Asynchronous reset in the middle of CALC
    press_seq(32'hC1A2F, 5);
    check("pre_rst_busy", 32'(kif.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(kif.busy), 32'd0);
    check("async_err",  32'(kif.err), 32'd0);
    check("async_disp", 32'(kif.disp_data), 32'h0);
    check("async_ack",  32'(kif.key_ack), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("ack_width", 32'(long_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
